// File: rtl/bicintp_pkg.sv
// Shared constants and index helpers for the bicubic coefficient generator.
// Fold and reverse helpers keep the symmetric-table mapping in one place.
package bicintp_pkg;

    localparam int DEF_PHASES = 32;
    localparam int DEF_TAPS   = 4;
    localparam int DEF_CW     = 8;

    // Output tap k of a mirrored phase comes from stored tap TAPS-1-k.
    function automatic int unsigned rev_tap(input int unsigned k, input int unsigned taps);
        return taps - 1 - k;
    endfunction

    // Phase p above the midpoint reuses the entry of phase PHASES-p.
    function automatic int unsigned fold_phase(input int unsigned p, input int unsigned phases);
        return phases - p;
    endfunction

endpackage

// File: rtl/bicintp_coef_bank.sv
// Double-banked coefficient RAM: one column per tap, per-column write enable,
// registered read of all columns at once. Address MSB selects the bank.
module bicintp_coef_bank
    import bicintp_pkg::*;
#(
    parameter int PHASES = DEF_PHASES,
    parameter int TAPS   = DEF_TAPS,
    parameter int CW     = DEF_CW,
    localparam int AW    = $clog2(PHASES) + 1
) (
    input  logic                 clk,
    input  logic [TAPS-1:0]      wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [CW-1:0]        wr_data_i,
    input  logic                 rd_en_i,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [TAPS*CW-1:0]   rd_data_o
);

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_col
            logic [CW-1:0] mem [2*PHASES];
            logic [CW-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en_i[gi]) begin
                    mem[wr_addr_i] <= wr_data_i;
                end
                if (rd_en_i) begin
                    rd_q <= mem[rd_addr_i];
                end
            end

            // Tap 0 sits in the most significant slice.
            assign rd_data_o[(TAPS-1-gi)*CW +: CW] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/bicintp_coef_gen.sv
// Bicubic coefficient generator: bank swap/mode control, shadow-bank writes and
// two independent 2-stage lookup pipelines (h and v) with optional symmetric folding.
module bicintp_coef_gen
    import bicintp_pkg::*;
#(
    parameter int PHASES = DEF_PHASES,
    parameter int TAPS   = DEF_TAPS,
    parameter int CW     = DEF_CW,
    parameter int PH_W   = $clog2(PHASES),
    parameter int TW     = $clog2(TAPS)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 sof,
    input  logic                 sym_mode,
    input  logic                 cfg_wr_en,
    input  logic                 cfg_wr_dir,
    input  logic [PH_W-1:0]      cfg_wr_phase,
    input  logic [TW-1:0]        cfg_wr_tap,
    input  logic [CW-1:0]        cfg_wr_data,
    input  logic                 cfg_swap,
    output logic                 bank_active,
    output logic                 swap_pending,
    input  logic                 h_req,
    input  logic [PH_W-1:0]      h_phase,
    output logic                 h_vld,
    output logic [TAPS*CW-1:0]   h_coef,
    input  logic                 v_req,
    input  logic [PH_W-1:0]      v_phase,
    output logic                 v_vld,
    output logic [TAPS*CW-1:0]   v_coef
);

    logic bank_q, bank_d;
    logic pend_q, pend_d;
    logic sym_q,  sym_d;

    always_comb begin
        bank_d = bank_q;
        pend_d = pend_q;
        sym_d  = sym_q;
        if (sof) begin
            sym_d = sym_mode;
            // A swap requested in the sof cycle itself is honoured immediately.
            if (pend_q || cfg_swap) begin
                bank_d = ~bank_q;
                pend_d = 1'b0;
            end
        end else if (cfg_swap) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
            sym_q  <= 1'b0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
            sym_q  <= sym_d;
        end
    end

    assign bank_active  = bank_q;
    assign swap_pending = pend_q;

    logic [TAPS-1:0] tap_sel;
    logic [PH_W:0]   wr_addr;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap_sel
            assign tap_sel[gi] = (cfg_wr_tap == TW'(gi));
        end
    endgenerate

    assign wr_addr = {~bank_q, cfg_wr_phase};

    logic                req_a   [2];
    logic [PH_W-1:0]     phase_a [2];
    logic                vld_a   [2];
    logic [TAPS*CW-1:0]  coef_a  [2];

    assign req_a[0]   = h_req;
    assign req_a[1]   = v_req;
    assign phase_a[0] = h_phase;
    assign phase_a[1] = v_phase;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dir
            logic                mirror;
            logic [PH_W-1:0]     rd_phase;
            logic [TAPS-1:0]     wr_en;
            logic [TAPS*CW-1:0]  rd_data;
            logic [TAPS*CW-1:0]  rev_data;
            logic [TAPS*CW-1:0]  coef_d;
            logic [TAPS*CW-1:0]  coef_q;
            logic                vld1_q, mir1_q, vld2_q;

            always_comb begin
                mirror   = sym_q && (phase_a[gi] > PH_W'(PHASES/2));
                rd_phase = mirror ? PH_W'(fold_phase(32'(phase_a[gi]), PHASES)) : phase_a[gi];
            end

            assign wr_en = (cfg_wr_en && (cfg_wr_dir == 1'(gi))) ? tap_sel : '0;

            bicintp_coef_bank #(
                .PHASES (PHASES),
                .TAPS   (TAPS),
                .CW     (CW)
            ) u_bank (
                .clk       (sys_clk),
                .wr_en_i   (wr_en),
                .wr_addr_i (wr_addr),
                .wr_data_i (cfg_wr_data),
                .rd_en_i   (req_a[gi]),
                .rd_addr_i ({bank_q, rd_phase}),
                .rd_data_o (rd_data)
            );

            for (genvar gk = 0; gk < TAPS; gk++) begin : g_rev
                assign rev_data[(TAPS-1-gk)*CW +: CW] =
                    rd_data[(TAPS-1-rev_tap(gk, TAPS))*CW +: CW];
            end

            always_comb begin
                coef_d = coef_q;
                if (vld1_q) begin
                    coef_d = mir1_q ? rev_data : rd_data;
                end
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    vld1_q <= 1'b0;
                    mir1_q <= 1'b0;
                    vld2_q <= 1'b0;
                    coef_q <= '0;
                end else begin
                    vld1_q <= req_a[gi];
                    mir1_q <= mirror;
                    vld2_q <= vld1_q;
                    coef_q <= coef_d;
                end
            end

            assign vld_a[gi]  = vld2_q;
            assign coef_a[gi] = coef_q;
        end
    endgenerate

    assign h_vld  = vld_a[0];
    assign h_coef = coef_a[0];
    assign v_vld  = vld_a[1];
    assign v_coef = coef_a[1];

endmodule

// File: tb/tb_bicintp_coef_gen.sv
// Directed bench for bicintp_coef_gen: load/swap, shadow isolation, pipelining,
// symmetric folding, swap boundary and mid-lookup reset.
module tb_bicintp_coef_gen;

    localparam int PHASES = 32;
    localparam int TAPS   = 4;
    localparam int CW     = 8;
    localparam int PH_W   = 5;
    localparam int TW     = 2;

    logic                sys_clk;
    logic                sys_rst;
    logic                sof;
    logic                sym_mode;
    logic                cfg_wr_en;
    logic                cfg_wr_dir;
    logic [PH_W-1:0]     cfg_wr_phase;
    logic [TW-1:0]       cfg_wr_tap;
    logic [CW-1:0]       cfg_wr_data;
    logic                cfg_swap;
    logic                bank_active;
    logic                swap_pending;
    logic                h_req;
    logic [PH_W-1:0]     h_phase;
    logic                h_vld;
    logic [TAPS*CW-1:0]  h_coef;
    logic                v_req;
    logic [PH_W-1:0]     v_phase;
    logic                v_vld;
    logic [TAPS*CW-1:0]  v_coef;

    int checks = 0;
    int errors = 0;

    bicintp_coef_gen #(
        .PHASES (PHASES),
        .TAPS   (TAPS),
        .CW     (CW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .sof          (sof),
        .sym_mode     (sym_mode),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_dir   (cfg_wr_dir),
        .cfg_wr_phase (cfg_wr_phase),
        .cfg_wr_tap   (cfg_wr_tap),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_swap     (cfg_swap),
        .bank_active  (bank_active),
        .swap_pending (swap_pending),
        .h_req        (h_req),
        .h_phase      (h_phase),
        .h_vld        (h_vld),
        .h_coef       (h_coef),
        .v_req        (v_req),
        .v_phase      (v_phase),
        .v_vld        (v_vld),
        .v_coef       (v_coef)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int p);
        logic [7:0] b;
        b = 8'(p);
        return {b, b + 8'h40, b + 8'h80, b + 8'hC0};
    endfunction

    task automatic write_word(input logic dir, input int ph, input logic [31:0] w);
        for (int t = 0; t < 4; t++) begin
            cfg_wr_en    = 1'b1;
            cfg_wr_dir   = dir;
            cfg_wr_phase = PH_W'(ph);
            cfg_wr_tap   = TW'(t);
            cfg_wr_data  = w[(3-t)*8 +: 8];
            tick();
        end
        cfg_wr_en = 1'b0;
    endtask

    task automatic h_lookup(input int ph, input logic [31:0] exp, input string tag);
        h_req   = 1'b1;
        h_phase = PH_W'(ph);
        tick();
        h_req = 1'b0;
        chk1({tag, "_vld_early"}, h_vld, 1'b0);
        tick();
        chk1({tag, "_vld"}, h_vld, 1'b1);
        chk32(tag, h_coef, exp);
        $display("h lookup %s phase %0d -> %h", tag, ph, h_coef);
    endtask

    task automatic v_lookup(input int ph, input logic [31:0] exp, input string tag);
        v_req   = 1'b1;
        v_phase = PH_W'(ph);
        tick();
        v_req = 1'b0;
        chk1({tag, "_vld_early"}, v_vld, 1'b0);
        tick();
        chk1({tag, "_vld"}, v_vld, 1'b1);
        chk32(tag, v_coef, exp);
        $display("v lookup %s phase %0d -> %h", tag, ph, v_coef);
    endtask

    task automatic pulse_swap();
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
    endtask

    task automatic pulse_sof(input logic mode);
        sof      = 1'b1;
        sym_mode = mode;
        tick();
        sof = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; sof = 1'b0; sym_mode = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_dir = 1'b0; cfg_wr_phase = '0; cfg_wr_tap = '0;
        cfg_wr_data = '0; cfg_swap = 1'b0;
        h_req = 1'b0; h_phase = '0; v_req = 1'b0; v_phase = '0;
        tick();
        tick();
        chk1("rst_h_vld", h_vld, 1'b0);
        chk1("rst_v_vld", v_vld, 1'b0);
        chk1("rst_bank", bank_active, 1'b0);
        chk1("rst_pending", swap_pending, 1'b0);
        chk32("rst_h_coef", h_coef, 32'h0);
        chk32("rst_v_coef", v_coef, 32'h0);
        sys_rst = 1'b0;
        tick();

        // Load bank 1 while bank 0 is active, then swap.
        write_word(1'b0, 5, 32'hF0602010);
        write_word(1'b1, 5, 32'hAABBCCDD);
        pulse_swap();
        chk1("swap_armed", swap_pending, 1'b1);
        chk1("bank_before_sof", bank_active, 1'b0);
        tick(); tick(); tick();
        chk1("pending_holds", swap_pending, 1'b1);
        pulse_sof(1'b0);
        chk1("bank_after_sof", bank_active, 1'b1);
        chk1("pending_cleared", swap_pending, 1'b0);
        h_lookup(5, 32'hF0602010, "load_swap");

        // Shadow bank 0 writes stay invisible until the next swap.
        write_word(1'b1, 5, 32'h11223344);
        for (int p = 0; p < PHASES; p++) begin
            write_word(1'b0, p, pat(p));
        end
        v_lookup(5, 32'hAABBCCDD, "shadow_iso");
        pulse_swap();
        pulse_sof(1'b0);
        chk1("bank_back_0", bank_active, 1'b0);
        v_lookup(5, 32'h11223344, "after_swap");

        // Back-to-back h requests with concurrent v requests.
        for (int i = 0; i <= PHASES; i++) begin
            h_req   = (i < PHASES);
            h_phase = PH_W'(i);
            v_req   = (i < PHASES);
            v_phase = PH_W'(5);
            tick();
            if (i >= 1) begin
                chk1("pipe_h_vld", h_vld, 1'b1);
                chk32("pipe_h_coef", h_coef, pat(i - 1));
                chk1("pipe_v_vld", v_vld, 1'b1);
                chk32("pipe_v_coef", v_coef, 32'h11223344);
                $display("pipe beat %0d h=%h v=%h", i - 1, h_coef, v_coef);
            end
        end
        h_req = 1'b0;
        v_req = 1'b0;
        tick();
        chk1("pipe_h_end", h_vld, 1'b0);
        chk1("pipe_v_end", v_vld, 1'b0);

        // Symmetric mode, with cfg_swap coinciding with sof.
        write_word(1'b0, 8,  32'h01020304);
        write_word(1'b0, 16, 32'h0A0B0C0D);
        write_word(1'b0, 0,  32'h55667788);
        cfg_swap = 1'b1;
        sof      = 1'b1;
        sym_mode = 1'b1;
        tick();
        cfg_swap = 1'b0;
        sof      = 1'b0;
        chk1("same_cycle_swap_bank", bank_active, 1'b1);
        chk1("same_cycle_swap_pend", swap_pending, 1'b0);
        h_lookup(24, 32'h04030201, "sym_p24");
        h_lookup(16, 32'h0A0B0C0D, "sym_p16");
        h_lookup(0,  32'h55667788, "sym_p0");
        h_lookup(27, 32'h102060F0, "sym_p27");
        h_lookup(8,  32'h01020304, "sym_p8");
        pulse_sof(1'b0);
        chk1("sof_no_swap_bank", bank_active, 1'b1);

        // Request, swap, sof and a shadow write all in one cycle.
        h_req        = 1'b1;
        h_phase      = PH_W'(5);
        cfg_swap     = 1'b1;
        sof          = 1'b1;
        sym_mode     = 1'b0;
        cfg_wr_en    = 1'b1;
        cfg_wr_dir   = 1'b0;
        cfg_wr_phase = PH_W'(6);
        cfg_wr_tap   = TW'(0);
        cfg_wr_data  = 8'hEE;
        tick();
        cfg_swap  = 1'b0;
        sof       = 1'b0;
        cfg_wr_en = 1'b0;
        chk1("bnd_bank", bank_active, 1'b0);
        chk1("bnd_pending", swap_pending, 1'b0);
        chk1("bnd_vld_early", h_vld, 1'b0);
        tick();
        h_req = 1'b0;
        chk1("bnd_old_vld", h_vld, 1'b1);
        chk32("bnd_old_bank", h_coef, 32'hF0602010);
        $display("boundary old-bank h=%h", h_coef);
        tick();
        chk1("bnd_new_vld", h_vld, 1'b1);
        chk32("bnd_new_bank", h_coef, pat(5));
        $display("boundary new-bank h=%h", h_coef);
        h_lookup(6, 32'hEE4686C6, "wr_at_swap");

        // Repeated swap pulses toggle the bank only once.
        pulse_swap();
        pulse_swap();
        chk1("dbl_pending", swap_pending, 1'b1);
        pulse_sof(1'b0);
        chk1("dbl_bank", bank_active, 1'b1);
        chk1("dbl_pend_clr", swap_pending, 1'b0);
        pulse_sof(1'b0);
        chk1("dbl_no_second", bank_active, 1'b1);

        // Reset with two lookups in flight and a swap armed.
        pulse_swap();
        h_req   = 1'b1;
        h_phase = PH_W'(5);
        tick();
        tick();
        h_req   = 1'b0;
        sys_rst = 1'b1;
        #1;
        chk1("mid_rst_vld", h_vld, 1'b0);
        chk32("mid_rst_coef", h_coef, 32'h0);
        chk1("mid_rst_bank", bank_active, 1'b0);
        chk1("mid_rst_pend", swap_pending, 1'b0);
        tick();
        tick();
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("post_rst_h_vld", h_vld, 1'b0);
            chk1("post_rst_v_vld", v_vld, 1'b0);
        end
        chk32("post_rst_coef", h_coef, 32'h0);
        chk1("post_rst_bank", bank_active, 1'b0);
        chk1("post_rst_pend", swap_pending, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
